rv_fifo: RTL
============

# rv_fifo

Parametrised successor to the single-entry ready/valid register: a first-word-fall-through FIFO of configurable width and depth with real backpressure, fill level and asynchronous active-low reset. It sits between any ready/valid producer and consumer in the design as a drop-in elastic buffer. It keeps the same write-side (`w*`) and read-side (`r*`) port naming.

## Interface
- `DATA_WIDTH`, 32: payload width in bits.
- `DEPTH`, 4: number of entries; power of two, >= 2.
- `INITVAL`, 32'd0: value driven on `rd_o` while the FIFO is empty; truncated to `DATA_WIDTH`.
- `clk` in 1: single clock, all state updates on posedge.
- `rstn` in 1: reset, asynchronous, active-low.
- `wv_i` in 1: write valid.
- `wr_o` out 1: write ready; high when not full.
- `wd_i` in `DATA_WIDTH`: write data.
- `rv_o` out 1: read valid; high when not empty.
- `rr_i` in 1: read ready.
- `rd_o` out `DATA_WIDTH`: head-of-queue data.
- `level_o` out `$clog2(DEPTH)+1`: current occupancy, 0..`DEPTH`.

## Operation
- Storage: `DEPTH` x `DATA_WIDTH` array, written at `wptr`, read at `rptr`.
- Pointers are `AW+1` bits, where `AW = $clog2(DEPTH)`. The MSB is the wrap bit.
  - Empty when `wptr == rptr`.
  - Full when the low `AW` bits are equal and the MSBs differ.
- Push: `wv_i & wr_o`. Writes `wd_i` at `wptr[AW-1:0]`, then `wptr` increments (natural wrap).
- Pop: `rv_o & rr_i`. `rptr` increments.
- `level_o` is a registered counter:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- `wr_o = (level_o != DEPTH)` and `rv_o = (level_o != 0)`. Both are decoded from registered state, with no combinational path from `wv_i` or `rr_i`.
- `rd_o = rv_o ? mem[rptr] : INITVAL`.
- Full with `wv_i=1, rr_i=1`: the pop is accepted and the push is rejected because `wr_o=0`. Level goes to `DEPTH-1`. The producer must hold its data.
- Empty with `wv_i=1, rr_i=1` (bypass off): the push is accepted and no pop occurs. Level goes to 1.
- Data arriving while `wv_i=0` is ignored. The input data is never sampled without a push.
- Reset (`rstn` low) clears `wptr`, `rptr` and `level_o` immediately, regardless of `clk`.
  - Outputs go to `wr_o=1`, `rv_o=0`, `level_o=0`, `rd_o=INITVAL`.
  - Array contents are not reset.
  - Reset mid-transfer discards all queued entries.

## Timing
- Write-to-read latency is 1 cycle: data pushed at edge N is visible on `rd_o` with `rv_o=1` after edge N.
- Full throughput of 1 push and 1 pop per cycle in steady state.
- `wr_o` deasserts the cycle after the push that fills the FIFO.
- `rv_o` deasserts the cycle after the pop that empties it.
- Reset release is synchronous-safe: the first push is accepted on the first posedge after `rstn` rises.

## Configuration
- `RV_FIFO_BYPASS_EN` defined: zero-latency bypass when empty.
  - `rv_o = (level_o != 0) | wv_i`.
  - `rd_o = (level_o == 0) ? wd_i : mem[rptr]`.
  - When empty with `wv_i & rr_i`, the word passes straight through. It is not stored, and neither pointers nor `level_o` change.
  - When empty with `wv_i & !rr_i`, the word is stored as normal.
  - `INITVAL` is shown only when empty and `wv_i=0`.
  - Adds a combinational path from the write-side inputs to `rv_o` and `rd_o`.
- `RV_FIFO_BYPASS_EN` undefined: behaviour as in Operation and Timing, with all outputs decoded from registered state only.

## Structure
- Shared package `rv_pkg` holds:
  - the `clog2`-based pointer-width helper;
  - the push/pop handshake macros or functions, shared with other ready/valid blocks.
- One natural sub-module, `rv_fifo_mem`:
  - simple dual-port array with synchronous write and asynchronous read;
  - ports `clk`, `we`, `waddr`, `wdata`, `raddr`, `rdata`;
  - no reset;
  - isolates the storage for later block-RAM mapping.

## Test plan
- Reset: hold `rstn=0` mid-stream with 3 entries queued -> immediately `level_o=0`, `rv_o=0`, `wr_o=1`, `rd_o=INITVAL`. The next pushed word `0xA5` appears first.
- Fill: `DEPTH=4`, push `1,2,3,4` with `rr_i=0` -> `wr_o=0` after the 4th push and `level_o=4`. A 5th word held on `wd_i` is not stored.
- Drain: then `rr_i=1` with `wv_i=0` -> `rd_o` reads `1,2,3,4` on consecutive cycles. `rv_o=0` after the 4th pop.
- Streaming: `wv_i=rr_i=1` for 20 cycles with incrementing data -> output is in order with no gaps after 1 cycle, `level_o` stays 1, and the pointers wrap correctly.
- Full boundary: full FIFO with `wv_i=rr_i=1` -> one pop, push rejected, `level_o=3`. The held word is accepted on the next cycle.
- Bypass (`RV_FIFO_BYPASS_EN`): empty FIFO with `wv_i=rr_i=1` and `wd_i=0x55` -> `rv_o=1` and `rd_o=0x55` in the same cycle, `level_o` stays 0. Without the macro, the word appears one cycle later.

Source files
------------

// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Helpers shared by the ready/valid blocks of the design:
//   ptr_width() - width of a wrap-bit FIFO pointer for a given depth
//   hs_fire()   - a ready/valid handshake completes this cycle
// -----------------------------------------------------------------------------
package rv_pkg;

    // Pointer carries one extra MSB so that full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage : rv_pkg

// File: rtl/rv_fifo_mem.sv
// -----------------------------------------------------------------------------
// rv_fifo_mem
// Simple dual-port storage array for rv_fifo: synchronous write, asynchronous
// read. Kept separate so the array can later be mapped onto block RAM.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
// -----------------------------------------------------------------------------
module rv_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the FIFO pointers,
    // and leaving it unreset lets synthesis map it onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : rv_fifo_mem

// File: rtl/rv_fifo.sv
// -----------------------------------------------------------------------------
// rv_fifo
// First-word-fall-through FIFO with ready/valid on both sides, registered fill
// level and asynchronous active-low reset. Drop-in elastic buffer.
// Ports:
//   clk      - clock, all state on posedge
//   rstn     - asynchronous active-low reset
//   wv_i     - write valid
//   wr_o     - write ready (not full)
//   wd_i     - write data
//   rv_o     - read valid (not empty)
//   rr_i     - read ready
//   rd_o     - head-of-queue data, INITVAL when empty
//   level_o  - occupancy, 0..DEPTH
// Build option:
//   RV_FIFO_BYPASS_EN - when defined, a write into an empty FIFO is presented
//   on the read side in the same cycle (combinational path wv_i/wd_i to
//   rv_o/rd_o). When undefined, all outputs decode from registered state.
// -----------------------------------------------------------------------------
module rv_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] INITVAL    = 32'd0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   wv_i,
    output logic                   wr_o,
    input  logic [DATA_WIDTH-1:0]  wd_i,
    output logic                   rv_o,
    input  logic                   rr_i,
    output logic [DATA_WIDTH-1:0]  rd_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0]         LEVEL_FULL = LW'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] INIT_DATA  = DATA_WIDTH'(INITVAL);

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  empty;
    logic                  bypass;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign empty = (level_q == '0);
    assign wr_o  = (level_q != LEVEL_FULL);

`ifdef RV_FIFO_BYPASS_EN
    // Empty with both sides ready: the word goes straight through and the
    // FIFO state is left untouched.
    assign bypass = empty & wv_i & rr_i;
    assign rv_o   = !empty | wv_i;
    assign rd_o   = !empty ? mem_rdata : (wv_i ? wd_i : INIT_DATA);
`else
    assign bypass = 1'b0;
    assign rv_o   = !empty;
    assign rd_o   = rv_o ? mem_rdata : INIT_DATA;
`endif

    assign push = hs_fire(wv_i, wr_o) & !bypass;
    assign pop  = hs_fire(rv_o, rr_i) & !bypass;

    // NOTE: every always_comb output gets its hold value first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge value regardless of block evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

    rv_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q[AW-1:0]),
        .wdata (wd_i),
        .raddr (rptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

endmodule : rv_fifo
